// File: rtl/fifo2axis.sv
// Unpacks wide frame-buffer FIFO words into a video AXI4-Stream (TUSER at frame start, TLAST at end of line).
// Optional stall counter: define FIFO2AXIS_UNDERFLOW_EN to enable underflow_cnt.
module fifo2axis #(
    parameter int FAW             = 8,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH = 128,
    parameter int H_ACTIVE        = 1920,
    parameter int V_ACTIVE        = 1080,
    parameter int FRAME_DELAY     = 2
) (
    input  logic                                                     M_AXIS_ACLK,
    input  logic                                                     M_AXIS_ARESET,
    input  logic                                                     stream_en,
    input  logic                                                     frd_vld,
    input  logic [AXI4_DATA_WIDTH-1:0]                               frd_dat,
    input  logic                                                     frd_empty,
    input  logic [FAW:0]                                             frd_cnt,
    output logic                                                     frd_rdy,
    output logic                                                     M_AXIS_TVALID,
    output logic [AXIS_DATA_WIDTH-1:0]                               M_AXIS_TDATA,
    output logic [AXIS_DATA_WIDTH/8-1:0]                             M_AXIS_TSTRB,
    output logic                                                     M_AXIS_TLAST,
    output logic                                                     M_AXIS_USER,
    input  logic                                                     M_AXIS_TREADY,
    output logic [((FRAME_DELAY > 2) ? $clog2(FRAME_DELAY) : 1)-1:0] frame_cnt,
    output logic [15:0]                                              underflow_cnt,
    output logic                                                     dbg_state
);
    // Handshake: a beat transfers on a cycle with TVALID & TREADY; a FIFO word is popped on frd_vld & frd_rdy.
    localparam int R   = AXI4_DATA_WIDTH / AXIS_DATA_WIDTH;
    localparam int BW  = (R > 2) ? $clog2(R) : 1;
    localparam int XW  = (H_ACTIVE > 2) ? $clog2(H_ACTIVE) : 1;
    localparam int YW  = (V_ACTIVE > 2) ? $clog2(V_ACTIVE) : 1;
    localparam int FCW = (FRAME_DELAY > 2) ? $clog2(FRAME_DELAY) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [AXI4_DATA_WIDTH-1:0] hold_q, hold_d;
    logic                       hold_vld_q, hold_vld_d;
    logic [BW-1:0]              b_q, b_d;
    logic [XW-1:0]              x_q, x_d;
    logic [YW-1:0]              y_q, y_d;
    logic [FCW-1:0]             frame_cnt_q, frame_cnt_d;

    logic beat_acc;
    logic word_done;
    logic line_end;
    logic frame_end;
    logic frame_active;
    logic pop;
    logic unused_status;

    assign unused_status = ^{frd_empty, frd_cnt};

    assign beat_acc     = hold_vld_q & M_AXIS_TREADY;
    assign word_done    = (b_q == BW'(R - 1));
    assign line_end     = (x_q == XW'(H_ACTIVE - 1));
    assign frame_end    = beat_acc & line_end & (y_q == YW'(V_ACTIVE - 1));
    assign frame_active = (x_q != '0) || (y_q != '0);

    // No pop on the closing beat of a frame when streaming stops, so nothing is left in hold while IDLE.
    assign frd_rdy = (state_q == RUN) & (~hold_vld_q | (word_done & beat_acc))
                     & ~(frame_end & ~stream_en);
    assign pop     = frd_rdy & frd_vld;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        b_d         = b_q;
        x_d         = x_q;
        y_d         = y_q;
        frame_cnt_d = frame_cnt_q;

        if (pop) begin
            hold_d     = frd_dat;
            hold_vld_d = 1'b1;
            b_d        = '0;
        end else if (beat_acc) begin
            hold_d = hold_q << AXIS_DATA_WIDTH;
            b_d    = b_q + 1'b1;
            if (word_done) begin
                hold_vld_d = 1'b0;
            end
        end

        if (beat_acc) begin
            if (line_end) begin
                x_d = '0;
                if (y_q == YW'(V_ACTIVE - 1)) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        if (frame_end) begin
            frame_cnt_d = (frame_cnt_q == FCW'(FRAME_DELAY - 1)) ? '0 : frame_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: if (stream_en) state_d = RUN;
            RUN:  if (frame_end && !stream_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            b_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            b_q         <= b_d;
            x_q         <= x_d;
            y_q         <= y_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef FIFO2AXIS_UNDERFLOW_EN
    logic [15:0] underflow_cnt_q, underflow_cnt_d;

    always_comb begin
        underflow_cnt_d = underflow_cnt_q;
        if ((state_q == RUN) && frame_active && !hold_vld_q && (underflow_cnt_q != 16'hFFFF)) begin
            underflow_cnt_d = underflow_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            underflow_cnt_q <= '0;
        end else begin
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    assign underflow_cnt = underflow_cnt_q;
`else
    logic unused_frame_active;
    assign unused_frame_active = frame_active;
    assign underflow_cnt       = 16'd0;
`endif

    // USER/TLAST are qualified by TVALID so they read 0 while no beat is presented.
    assign M_AXIS_TVALID = hold_vld_q;
    assign M_AXIS_TDATA  = hold_q[AXI4_DATA_WIDTH-1 -: AXIS_DATA_WIDTH];
    assign M_AXIS_TSTRB  = '1;
    assign M_AXIS_TLAST  = hold_vld_q & line_end;
    assign M_AXIS_USER   = hold_vld_q & (x_q == '0) & (y_q == '0);
    assign frame_cnt     = frame_cnt_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fifo2axis.sv
// Directed + randomized-data bench for fifo2axis: FIFO model, expected-beat queue, summary report.
module tb_fifo2axis;
  localparam int FAW = 4;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int R = DW / AW;
  localparam int H = 8;
  localparam int V = 2;
  localparam int FD = 2;
  localparam int BEATS = H * V;
  localparam int WORDS = BEATS / R;

  logic clk = 1'b0;
  logic rst;
  logic stream_en;
  logic frd_vld;
  logic [DW-1:0] frd_dat;
  logic frd_empty;
  logic [FAW:0] frd_cnt;
  logic frd_rdy;
  logic tvalid;
  logic [AW-1:0] tdata;
  logic [AW/8-1:0] tstrb;
  logic tlast;
  logic tuser;
  logic tready;
  logic [0:0] frame_cnt;
  logic [15:0] underflow_cnt;
  logic dbg_state;

  fifo2axis #(
    .FAW(FAW), .AXIS_DATA_WIDTH(AW), .AXI4_DATA_WIDTH(DW),
    .H_ACTIVE(H), .V_ACTIVE(V), .FRAME_DELAY(FD)
  ) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .stream_en(stream_en),
    .frd_vld(frd_vld), .frd_dat(frd_dat), .frd_empty(frd_empty), .frd_cnt(frd_cnt),
    .frd_rdy(frd_rdy), .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb),
    .M_AXIS_TLAST(tlast), .M_AXIS_USER(tuser), .M_AXIS_TREADY(tready),
    .frame_cnt(frame_cnt), .underflow_cnt(underflow_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: expected beats {user, last, data}, FIFO contents
  logic [AW+1:0] exp_q[$];
  logic [DW-1:0] fifo_q[$];

  logic s_tv, s_rdy, s_state;
  logic [AW+1:0] s_beat;
  logic [AW/8-1:0] s_strb;
  logic [0:0] s_fc;
  logic [15:0] s_uf;
  logic prev_stall = 1'b0;
  logic [AW+1:0] prev_beat = '0;
  logic toggle_ready = 1'b0;
  int beats, pops, low_cnt, cyc, first_cyc, last_cyc;
  int exp_uf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    frd_vld = (fifo_q.size() != 0);
    frd_dat = frd_vld ? fifo_q[0] : '0;
    frd_empty = !frd_vld;
    frd_cnt = (FAW + 1)'(fifo_q.size());
  endtask

  // word of frame beats [4*tag .. 4*tag+3] most significant first, random base offset in data
  task automatic push_word(input int widx, input logic [AW-1:0] base);
    logic [DW-1:0] w;
    logic [AW-1:0] d;
    int k;
    w = '0;
    for (int j = 0; j < R; j++) begin
      d = base + AW'(R * widx + j);
      w[DW-1-AW*j -: AW] = d;
      k = R * widx + j;
      exp_q.push_back({(k == 0), ((k % H) == H - 1), d});
    end
    fifo_q.push_back(w);
  endtask

  task automatic push_frame(input int first_word, input int n, input logic [AW-1:0] base);
    for (int i = first_word; i < first_word + n; i++) push_word(i, base);
    drive_fifo();
  endtask

  // one clock: sample at negedge, update model after posedge
  task automatic tick();
    logic acc, pop;
    @(negedge clk);
    s_tv = tvalid;
    s_rdy = frd_rdy;
    s_beat = {tuser, tlast, tdata};
    s_strb = tstrb;
    s_fc = frame_cnt;
    s_uf = underflow_cnt;
    s_state = dbg_state;
    acc = s_tv & tready & ~rst;
    pop = frd_vld & frd_rdy & ~rst;
    if (!rst && prev_stall) chk("stall_hold", {s_tv, s_beat}, {1'b1, prev_beat});
    prev_stall = s_tv & ~tready & ~rst;
    prev_beat = s_beat;
    if (!s_tv) low_cnt++;
    if (acc) begin
      if (exp_q.size() == 0) chk("extra_beat", 64'(exp_q.size()), 64'd1);
      else chk("beat", s_beat, exp_q.pop_front());
      if (beats == 0) first_cyc = cyc;
      last_cyc = cyc;
      beats++;
    end
    if (pop) pops++;
    @(posedge clk);
    cyc++;
    #1;
    if (pop) void'(fifo_q.pop_front());
    drive_fifo();
    tready = toggle_ready ? ~tready : 1'b1;
  endtask

  task automatic run_until(input int target);
    int budget;
    budget = 300;
    while (beats < target && budget > 0) begin
      tick();
      budget--;
    end
    if (beats < target) chk("timeout", 64'(beats), 64'(target));
  endtask

  task automatic start_phase();
    beats = 0;
    pops = 0;
    low_cnt = 0;
  endtask

  initial begin
    logic [AW-1:0] base;
    cyc = 0;
    rst = 1'b1;
    stream_en = 1'b0;
    tready = 1'b1;
    drive_fifo();
    `ifdef FIFO2AXIS_UNDERFLOW_EN
    exp_uf = 5;
    `else
    exp_uf = 0;
    `endif
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_frd_rdy", s_rdy, 0);
    chk("rst_tvalid", s_tv, 0);
    chk("rst_tdata_last_user", s_beat, 0);
    chk("rst_tstrb", s_strb, 4'hF);
    chk("rst_frame_cnt", s_fc, 0);
    chk("rst_underflow", s_uf, 0);
    chk("rst_state", s_state, 0);

    // frame 1: spec data 0..15, sustained rate, start latency
    start_phase();
    push_frame(0, WORDS, '0);
    stream_en = 1'b1;
    tick();
    chk("en_cycle_n_rdy", s_rdy, 0);
    tick();
    chk("en_n1_rdy", s_rdy, 1);
    chk("en_n1_tvalid", s_tv, 0);
    tick();
    chk("en_n2_tvalid", s_tv, 1);
    run_until(BEATS);
    chk("f1_sustained", 64'(last_cyc - first_cyc), 64'(BEATS - 1));
    chk("f1_pops", 64'(pops), 64'(WORDS));
    tick();
    chk("f1_frame_cnt", s_fc, 1);

    // frame 2: TREADY toggling, random data
    start_phase();
    base = AW'($urandom);
    push_frame(0, WORDS, base);
    toggle_ready = 1'b1;
    run_until(BEATS);
    toggle_ready = 1'b0;
    chk("f2_pops", 64'(pops), 64'(WORDS));
    tick();
    chk("f2_frame_cnt", s_fc, 0);

    // frame 3: one word, then FIFO empty, then the rest
    start_phase();
    base = AW'($urandom);
    push_frame(0, 1, base);
    run_until(R);
    low_cnt = 0;
    repeat (4) tick();
    push_frame(1, WORDS - 1, base);
    run_until(BEATS);
    chk("f3_tvalid_low", 64'(low_cnt), 64'd5);
    tick();
    chk("f3_frame_cnt", s_fc, 1);
    chk("f3_underflow", s_uf, 64'(exp_uf));

    // frame 4: stream_en dropped after beat 5, frame still completes
    start_phase();
    base = AW'($urandom);
    push_frame(0, WORDS, base);
    run_until(6);
    stream_en = 1'b0;
    run_until(BEATS);
    base = AW'($urandom);
    push_frame(0, WORDS, base);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_frd_rdy", s_rdy, 0);
      chk("idle_state", s_state, 0);
    end
    chk("f4_frame_cnt", s_fc, 0);
    chk("idle_fifo_kept", 64'(fifo_q.size()), 64'(WORDS));

    // frame 5: reset mid-frame at beat 6
    start_phase();
    stream_en = 1'b1;
    run_until(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    drive_fifo();
    tick();
    chk("midrst_tvalid", s_tv, 0);
    chk("midrst_frd_rdy", s_rdy, 0);
    chk("midrst_frame_cnt", s_fc, 0);
    chk("midrst_underflow", s_uf, 0);
    chk("midrst_state", s_state, 0);

    // frame 6: fresh frame after reset starts with USER
    start_phase();
    base = AW'($urandom);
    push_frame(0, WORDS, base);
    run_until(BEATS);
    tick();
    chk("f6_frame_cnt", s_fc, 1);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo2axis.md
# fifo2axis

Read-side counterpart of the AXIS→FIFO packer: pops wide AXI4-width words from the frame-buffer read FIFO, unpacks each into AXI4_DATA_WIDTH/AXIS_DATA_WIDTH AXIS beats (most-significant word first), and drives a video AXI4-Stream master with TUSER on frame start and TLAST at end of line. It sits between the AXI4 read engine's FIFO and the downstream video sink, on a single clock.

## Interface
- FAW, 8, FIFO depth 2^FAW; width of frd_cnt is FAW+1
- AXIS_DATA_WIDTH, 32, AXIS beat width
- AXI4_DATA_WIDTH, 128, FIFO word width; R = AXI4_DATA_WIDTH/AXIS_DATA_WIDTH, integer ≥2
- H_ACTIVE, 1920, beats per line; multiple of R
- V_ACTIVE, 1080, lines per frame
- FRAME_DELAY, 2, frame_cnt modulus (max 1024)
- M_AXIS_ACLK  in  1  sole clock
- M_AXIS_ARESET  in  1  synchronous, active-high reset
- stream_en  in  1  enables frame output; sampled only at frame boundaries
- frd_vld  in  1  FIFO head word valid (show-ahead)
- frd_dat  in  AXI4_DATA_WIDTH  FIFO head word
- frd_empty  in  1  FIFO empty, status only
- frd_cnt  in  FAW+1  FIFO fill, status only
- frd_rdy  out  1  pop; a word is consumed when frd_vld & frd_rdy
- M_AXIS_TVALID  out  1  beat valid
- M_AXIS_TDATA  out  AXIS_DATA_WIDTH  beat data
- M_AXIS_TSTRB  out  AXIS_DATA_WIDTH/8  always all ones
- M_AXIS_TLAST  out  1  last beat of line
- M_AXIS_USER  out  1  first beat of frame
- M_AXIS_TREADY  in  1  sink ready
- frame_cnt  out  clogb2(FRAME_DELAY-1)  completed-frame counter, mod FRAME_DELAY
- underflow_cnt  out  16  stall counter (see Configuration)

## Operation
- Holding register hold[AXI4_DATA_WIDTH-1:0], hold_vld, beat counter b (0..R-1), pixel counter x (0..H_ACTIVE-1), line counter y (0..V_ACTIVE-1).
- States: IDLE, RUN. IDLE→RUN when stream_en=1. In RUN, on acceptance of the beat with x=H_ACTIVE-1, y=V_ACTIVE-1: frame_cnt ← (frame_cnt==FRAME_DELAY-1)?0:frame_cnt+1; x,y←0; stay RUN if stream_en=1 else IDLE. stream_en changes mid-frame are ignored.
- frd_rdy = RUN & (~hold_vld | (b==R-1 & TVALID & TREADY)); popped word loads hold, hold_vld←1, b←0.
- TDATA = hold[AXI4_DATA_WIDTH-1 -: AXIS_DATA_WIDTH]; on each accepted beat hold shifts left by AXIS_DATA_WIDTH, b increments; on b==R-1 accepted without a new pop, hold_vld←0.
- TVALID = hold_vld. USER = (x==0 & y==0). TLAST = (x==H_ACTIVE-1). x wraps to 0 at H_ACTIVE-1 and y increments.
- AXIS rule: while TVALID & ~TREADY, TDATA/TLAST/USER/TVALID are held stable.
- Underflow: RUN, hold_vld=0, frd_vld=0, frame in progress (x|y nonzero) → TVALID low; output resumes on the next word without loss.
- Reset: all state cleared; FIFO contents not flushed (upstream owns flush).

## Timing
- Reset values: frd_rdy 0, TVALID 0, TDATA 0, TSTRB all ones, TLAST 0, USER 0, frame_cnt 0, underflow_cnt 0, state IDLE.
- Pop at cycle n → first beat TVALID at n+1.
- Sustained 1 beat/cycle with TREADY=1 and FIFO non-empty; last beat of a word and pop of the next occur in the same cycle.
- stream_en asserted at cycle n (IDLE) → RUN at n+1 → earliest frd_rdy at n+1 → first TVALID at n+2.
- Reset asserted mid-frame: outputs at reset values the following cycle; next frame starts with USER on its first beat.

## Configuration
- FIFO2AXIS_UNDERFLOW_EN defined: underflow_cnt increments (saturating at 16'hFFFF) every cycle in RUN with a frame in progress and TVALID=0; cleared only by reset.
- Not defined: underflow_cnt tied to 0; no counter logic.

## Test plan
- R=4, H_ACTIVE=8, V_ACTIVE=2, TREADY=1, FIFO preloaded with 4 words {32'h0,32'h1,32'h2,32'h3}, {4,5,6,7}…: 16 consecutive beats TDATA 0..15, USER only on beat 0, TLAST on beats 7 and 15, frame_cnt 0→1.
- Same frame, TREADY toggling 1,0,1,0: TDATA/TLAST/USER stable while stalled, all 16 beats delivered in order, exactly 4 pops.
- FIFO holds 1 word then empty for 5 cycles: beats 0..3, TVALID low 5 cycles, resumes with 4; with macro underflow_cnt=5, without it 0.
- stream_en deasserted at beat 5: frame completes through beat 15, state IDLE, frd_rdy stays 0 with frd_vld=1.
- Reset 1 cycle at beat 6: next cycle TVALID=0, counters 0; after release with stream_en=1, next beat carries USER=1.
- FRAME_DELAY=2, three frames streamed: frame_cnt sequence 1,0,1.
